// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide engine for the EX stage.
// Shift-add multiply and restoring divide, one bit per BUSY cycle.
// Divide-by-zero and signed-overflow divides resolve in IDLE and go
// straight to DONE.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a combinational
// 64-bit product and finish IDLE->DONE.
//
// Handshake: start_i is a level ("EX holds an M instruction"). The unit
// accepts it in IDLE when MemStall_in=0. stall_o stays high until the
// result is ready. done_o pulses in DONE with result_o valid, and stall_o
// is low then so ID/EX advances on the edge that ends DONE. MemStall_in
// freezes every register.
module ex_muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        MemStall_in,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [1:0]  dbg_state_o,
  output logic [4:0]  dbg_count_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic        neg_q, neg_d;
  logic [31:0] a_q, a_d;     // multiplicand / dividend (shifts left on divide)
  logic [31:0] b_q, b_d;     // multiplier (shifts right) / divisor
  logic [31:0] hi_q, hi_d;   // product high half / partial remainder
  logic [31:0] lo_q, lo_d;   // product low half / quotient
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic        sgn_a, sgn_b, res_neg, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic        div_ge;
  logic [31:0] hi_n, lo_n;

  // Negates the product over all 64 bits when needed, then picks low or high half.
  function automatic logic [31:0] mul_pick(input logic [1:0] op, input logic neg,
                                           input logic [63:0] prod);
    logic [63:0] p;
    p = neg ? (64'd0 - prod) : prod;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Operand decode: signedness, magnitudes, result sign and special cases.
  always_comb begin
    sgn_a    = rs1_data_i[31] & ((funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                                 (funct3_i == 3'b100) || (funct3_i == 3'b110));
    sgn_b    = rs2_data_i[31] & ((funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                                 (funct3_i == 3'b110));
    a_mag    = sgn_a ? (32'd0 - rs1_data_i) : rs1_data_i;
    b_mag    = sgn_b ? (32'd0 - rs2_data_i) : rs2_data_i;
    // REM takes the dividend's sign; every other op takes sign(A) xor sign(B).
    res_neg  = (funct3_i == 3'b110) ? sgn_a : (sgn_a ^ sgn_b);
    div_zero = funct3_i[2] && (rs2_data_i == 32'd0);
    div_ovf  = funct3_i[2] && !funct3_i[0] && (rs1_data_i == 32'h8000_0000) &&
               (rs2_data_i == 32'hFFFF_FFFF);
  end

  // One iteration step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (b_q[0] ? a_q : 32'd0)};
    div_shift = {hi_q, a_q[31]};
    div_trial = div_shift - {1'b0, b_q};
    div_ge    = !div_trial[32];
    if (f3_q[2]) begin
      hi_n = div_ge ? div_trial[31:0] : div_shift[31:0];
      lo_n = {lo_q[30:0], div_ge};
    end else begin
      hi_n = mul_sum[32:1];
      lo_n = {mul_sum[0], lo_q[31:1]};
    end
  end

  // FSM next state and datapath updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          f3_d  = funct3_i;
          neg_d = res_neg;
          a_d   = a_mag;
          b_d   = b_mag;
          hi_d  = 32'd0;
          lo_d  = 32'd0;
          cnt_d = 5'd0;
          if (div_zero) begin
            result_d = funct3_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
            state_d  = DONE;
            done_d   = 1'b1;
          end else if (div_ovf) begin
            result_d = funct3_i[1] ? 32'd0 : 32'h8000_0000;
            state_d  = DONE;
            done_d   = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!funct3_i[2]) begin
            result_d = mul_pick(funct3_i[1:0], res_neg, {32'd0, a_mag} * {32'd0, b_mag});
            state_d  = DONE;
            done_d   = 1'b1;
`endif
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 5'd1;
        hi_d  = hi_n;
        lo_d  = lo_n;
        if (f3_q[2]) a_d = {a_q[30:0], 1'b0};
        else         b_d = {1'b0, b_q[31:1]};
        if (cnt_q == 5'd31) begin
          if (f3_q[2])
            result_d = f3_q[1] ? (neg_q ? (32'd0 - hi_n) : hi_n)
                               : (neg_q ? (32'd0 - lo_n) : lo_n);
          else
            result_d = mul_pick(f3_q[1:0], neg_q, {hi_n, lo_n});
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; MemStall_in freezes everything.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      f3_q     <= 3'd0;
      neg_q    <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else if (!MemStall_in) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Pipeline stall request and registered outputs.
  always_comb begin
    stall_o     = ((state_q == IDLE) && start_i) || (state_q == BUSY);
    done_o      = done_q;
    result_o    = result_q;
    dbg_state_o = state_q;
    dbg_count_o = cnt_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit (RV32M results,
// stall latency, MemStall freeze, async reset, back-to-back operations).
module tb_ex_muldiv_unit;

  logic        clk, rst_n, start, mem_stall;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        stall, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;
  logic [4:0]  dbg_count;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int FREEZE_LEN = 5;

  ex_muldiv_unit dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .funct3_i    (funct3),
    .rs1_data_i  (rs1),
    .rs2_data_i  (rs2),
    .MemStall_in (mem_stall),
    .stall_o     (stall),
    .done_o      (done),
    .result_o    (result),
    .dbg_state_o (dbg_state),
    .dbg_count_o (dbg_count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference RV32M behaviour built from wide arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs, ps;
    logic [63:0]        pu;
    logic signed [31:0] x, y, r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ubs = {32'd0, b};
    pu  = {32'd0, a} * {32'd0, b};
    x   = a;
    y   = b;
    case (f)
      3'd0: return pu[31:0];
      3'd1: begin ps = sa * sb;  return ps[63:32]; end
      3'd2: begin ps = sa * ubs; return ps[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = x / y; return r;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = x % y; return r;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Driver: called at a falling edge; leaves start high with the same
  // instruction, sitting in the IDLE cycle after DONE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int freeze_at, input int done_hold);
    int stall_cnt, guard, lat;
    bit froze;
    logic [31:0] exp;
    exp_q.push_back(ref_op(f, a, b));
    lat = exp_lat(f, a, b);
    if (freeze_at >= 0 && lat == 33) lat += FREEZE_LEN;
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    stall_cnt = 0; guard = 0; froze = 1'b0;
    #1;
    while (!done && guard < 300) begin
      if (stall) stall_cnt++;
      if (freeze_at >= 0 && !froze && dbg_state == S_BUSY && dbg_count == 5'(freeze_at)) begin
        froze = 1'b1;
        mem_stall = 1'b1;
        for (int i = 0; i < FREEZE_LEN; i++) begin
          @(negedge clk); #1;
          check_eq("freeze_count", {27'd0, dbg_count}, 32'(freeze_at));
          if (stall) stall_cnt++;
        end
        mem_stall = 1'b0;
      end
      @(negedge clk); #1;
      guard++;
    end
    check_eq("done_seen", {31'd0, done}, 32'd1);
    check_eq("stall_cycles", 32'(stall_cnt), 32'(lat));
    check_eq("stall_in_done", {31'd0, stall}, 32'd0);
    exp = exp_q.pop_front();
    check_eq("result", result, exp);
    if (done_hold > 0) begin
      mem_stall = 1'b1;
      for (int i = 0; i < done_hold; i++) begin
        @(negedge clk); #1;
        check_eq("done_held", {31'd0, done}, 32'd1);
        check_eq("result_held", result, exp);
      end
      mem_stall = 1'b0;
    end
    @(negedge clk); #1;
    check_eq("done_pulse_end", {31'd0, done}, 32'd0);
    check_eq("idle_after_done", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq("result_holds", result, exp);
  endtask

  task automatic idle_gap();
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int g;
    rst_n = 1'b0; start = 1'b0; mem_stall = 1'b0;
    funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    #1;
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Multiplies
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1, 0); idle_gap();
    check_eq("mul_const", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0); idle_gap();
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0); idle_gap();
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0); idle_gap();

    // Divides
    run_op(3'd4, 32'hFFFF_FFEC, 32'd6, -1, 0); idle_gap();
    run_op(3'd6, 32'hFFFF_FFEC, 32'd6, -1, 0); idle_gap();
    run_op(3'd5, 32'hFFFF_FFEC, 32'd6, -1, 0); idle_gap();

    // Special cases
    run_op(3'd5, 32'h1234, 32'd0, -1, 0); idle_gap();
    run_op(3'd6, 32'h1234, 32'd0, -1, 0); idle_gap();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0); idle_gap();
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0); idle_gap();

    // Freeze in BUSY, then freeze in DONE
    run_op(3'd5, 32'd100, 32'd7, 10, 0); idle_gap();
    run_op(3'd4, 32'hFFFF_FFEC, 32'd6, -1, 3); idle_gap();

    // Asynchronous reset mid-operation
    funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    g = 0;
    #1;
    while (!(dbg_state == S_BUSY && dbg_count == 5'd20) && g < 100) begin
      @(negedge clk); #1; g++;
    end
    check_eq("reached_count20", {27'd0, dbg_count}, 32'd20);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq("midrst_count", {27'd0, dbg_count}, 32'd0);
    check_eq("midrst_result", result, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, -1, 0); idle_gap();

    // Back-to-back: second instruction enters in the IDLE cycle after DONE
    run_op(3'd5, 32'd100, 32'd7, -1, 0);
    run_op(3'd7, 32'd100, 32'd7, -1, 0); idle_gap();

    // Random operations
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      run_op(rf, ra, rb, -1, 0);
      if ($urandom_range(0, 1) == 1) idle_gap();
    end
    idle_gap();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
